instr_loader: RTL and testbench

- Writer side of the instruction path: streams a program, byte by byte, into instruction memory.
- The control decoder later reads that memory back as opcodes.
- Assembles little-endian bytes into 32-bit words and writes them sequentially from word address 0.
- Holds the CPU in reset until the load completes, and flags any word whose opcode the control decoder does not support.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/opcode_check.sv | 19 +
 rtl/instr_loader.sv | 136 +++++++++++++
 tb/tb_instr_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: supported opcodes and the loader state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/opcode_check.sv
// Combinational check of a 7-bit opcode against the set the control decoder handles.
module opcode_check
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       valid
);

  // Membership test against the supported opcode list
  always_comb begin
    valid = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_LUI: valid = 1'b1;
      default:                   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Streams program bytes into instruction memory as little-endian 32-bit words,
// keeps the CPU in reset until the load finishes and flags unsupported opcodes.
module instr_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_t         state, state_next;
  logic [1:0]            byte_idx, byte_idx_next;
  logic [ADDR_WIDTH:0]   word_idx, word_idx_next;
  logic [ADDR_WIDTH:0]   len, len_next;
  logic [31:0]           word_buf, word_buf_next;
  logic                  err_next;
  logic [ADDR_WIDTH-1:0] err_addr_next;
  logic                  handshake;
  logic                  opcode_ok;

  opcode_check u_opcode_check (
    .opcode(mem_wdata[6:0]),
    .valid (opcode_ok)
  );

  // Next-state, byte assembly, word counting and error tracking
  always_comb begin
    state_next    = state;
    byte_idx_next = byte_idx;
    word_idx_next = word_idx;
    len_next      = len;
    word_buf_next = word_buf;
    err_next      = err;
    err_addr_next = err_addr;
    handshake     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (num_words == '0) begin
            state_next = DONE;
          end else begin
            len_next      = (num_words > MAX_LEN) ? MAX_LEN : num_words;
            word_idx_next = '0;
            byte_idx_next = '0;
            err_next      = 1'b0;
            err_addr_next = '0;
            state_next    = RECV;
          end
        end
      end
      RECV: begin
        handshake = byte_valid && byte_ready;
        if (handshake) begin
          case (byte_idx)
            2'd0:    word_buf_next[7:0]   = byte_data;
            2'd1:    word_buf_next[15:8]  = byte_data;
            2'd2:    word_buf_next[23:16] = byte_data;
            default: word_buf_next[31:24] = byte_data;
          endcase
          byte_idx_next = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_next = WRITE;
        end
      end
      WRITE: begin
        word_idx_next = word_idx + 1'b1;
        if (!opcode_ok) begin
          err_next = 1'b1;
          if (!err) err_addr_next = mem_addr;
        end
        state_next = ((word_idx + 1'b1) == len) ? DONE : RECV;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      word_idx <= '0;
      len      <= '0;
      word_buf <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      state    <= state_next;
      byte_idx <= byte_idx_next;
      word_idx <= word_idx_next;
      len      <= len_next;
      word_buf <= word_buf_next;
      err      <= err_next;
      err_addr <= err_addr_next;
    end
  end

  // Registered outputs decoded from the upcoming state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      byte_ready <= (state_next == RECV);
      mem_we     <= (state_next == WRITE);
      busy       <= (state_next == RECV) || (state_next == WRITE);
      done       <= (state_next == DONE);
      cpu_rst    <= (state_next != DONE);
      if (state_next == WRITE) begin
        mem_addr  <= word_idx[ADDR_WIDTH-1:0];
        mem_wdata <= word_buf_next;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: hand sequences, an opcode table and
// randomized loads compared against a simple list-based model of the load.
module tb_instr_loader;

  localparam int AW = 4;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cycle;
  } wr_t;

  typedef struct {
    logic [31:0] word;
    logic        exp_err;
  } vec_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          ready_cnt = 0;
  int          done_rise = 0;
  logic        done_prev = 1'b0;
  wr_t         writes[$];
  logic [31:0] stim_words[$];
  logic [6:0]  supported[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111};
  vec_t        vecs[12];
  bit          bp_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  // Monitor on the falling edge: log every write, byte_ready cycle and done rise
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) writes.push_back('{mem_addr, mem_wdata, cyc + 1});
    if (byte_ready) ready_cnt <= ready_cnt + 1;
    if (done && !done_prev) done_rise <= cyc + 1;
    done_prev <= done;
  end

  function automatic bit isSupported(input logic [6:0] op);
    foreach (supported[i]) if (supported[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    start = 1'b0;
    byte_valid = 1'b0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic startLoad(input int n);
    start = 1'b1;
    num_words = (AW + 1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waited = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (!byte_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!byte_ready) begin
      checkOutput("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
      byte_valid = 1'b0;
      return;
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap_max);
    for (int l = 0; l < 4; l++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      sendByte(w[8*l +: 8]);
    end
  endtask

  task automatic waitDone();
    int waited = 0;
    while (!done && waited < 200) begin
      tick();
      waited++;
    end
    if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Start a load of n words and stream every word of stim_words
  task automatic applyStimulus(input int n, input int gap_max);
    startLoad(n);
    foreach (stim_words[i]) sendWord(stim_words[i], gap_max);
    waitDone();
  endtask

  // Compare captured writes and final flags with the list model of stim_words
  task automatic checkLoad(input string tag, input int base);
    int   n;
    int   got;
    logic exp_err;
    int   exp_addr;
    n = stim_words.size();
    got = writes.size() - base;
    exp_err = 1'b0;
    exp_addr = 0;
    checkOutput({tag, "_count"}, got, n);
    for (int i = 0; i < n && i < got; i++) begin
      checkOutput({tag, "_addr"}, {28'd0, writes[base+i].addr}, i);
      checkOutput({tag, "_data"}, writes[base+i].data, stim_words[i]);
    end
    foreach (stim_words[i]) begin
      if (!exp_err && !isSupported(stim_words[i][6:0])) begin
        exp_err = 1'b1;
        exp_addr = i;
      end
    end
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    checkOutput({tag, "_err_addr"}, {28'd0, err_addr}, exp_addr);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          base;
    int          rc;
    int          k;
    logic [31:0] bpw;
    logic [31:0] w;
    int          len;

    vecs[0]  = '{32'h00000033, 1'b0};
    vecs[1]  = '{32'h00000013, 1'b0};
    vecs[2]  = '{32'h00000003, 1'b0};
    vecs[3]  = '{32'h00000023, 1'b0};
    vecs[4]  = '{32'h00000063, 1'b0};
    vecs[5]  = '{32'h0000006F, 1'b0};
    vecs[6]  = '{32'h00000037, 1'b0};
    vecs[7]  = '{32'h00000067, 1'b1};
    vecs[8]  = '{32'h00000017, 1'b1};
    vecs[9]  = '{32'h00000073, 1'b1};
    vecs[10] = '{32'h00000032, 1'b1};
    vecs[11] = '{32'hFFFFFFB3, 1'b0};

    // Reset state, sampled while reset is held
    #1 rst = 1'b1;
    #11;
    checkOutput("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_err_addr", {28'd0, err_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // Two-word load with continuous bytes
    base = writes.size();
    startLoad(2);
    checkOutput("t1_ready_after_start", {31'd0, byte_ready}, 32'd1);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    foreach (bp_pat[i]) begin end
    sendByte(8'h23); sendByte(8'hA0); sendByte(8'h20); sendByte(8'h00);
    sendByte(8'h63); sendByte(8'h04); sendByte(8'hB5); sendByte(8'h00);
    waitDone();
    tick();
    checkOutput("t1_count", writes.size() - base, 32'd2);
    if (writes.size() - base >= 2) begin
      checkOutput("t1_w0_data", writes[base].data, 32'h0020A023);
      checkOutput("t1_w0_addr", {28'd0, writes[base].addr}, 32'd0);
      checkOutput("t1_w1_data", writes[base+1].data, 32'h00B50463);
      checkOutput("t1_w1_addr", {28'd0, writes[base+1].addr}, 32'd1);
      checkOutput("t1_spacing", writes[base+1].cycle - writes[base].cycle, 32'd5);
      checkOutput("t1_done_latency", done_rise, writes[base+1].cycle + 1);
    end
    checkOutput("t1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("t1_err", {31'd0, err}, 32'd0);

    // Backpressure: only cycles with byte_valid advance the assembly
    bpw = 32'h000120B7;
    k = 0;
    startLoad(1);
    for (int i = 0; i < 7; i++) begin
      checkOutput("bp_ready", {31'd0, byte_ready}, 32'd1);
      byte_valid = bp_pat[i];
      byte_data = bp_pat[i] ? bpw[8*k +: 8] : 8'hEE;
      tick();
      if (bp_pat[i]) k++;
    end
    byte_valid = 1'b0;
    checkOutput("bp_mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("bp_wdata", mem_wdata, bpw);
    checkOutput("bp_addr", {28'd0, mem_addr}, 32'd0);
    checkOutput("bp_ready_in_write", {31'd0, byte_ready}, 32'd0);
    tick();
    checkOutput("bp_we_single", {31'd0, mem_we}, 32'd0);
    waitDone();

    // Unsupported opcodes: first bad word's address sticks
    stim_words = '{32'h00000013, 32'hFFFFFFFF, 32'h0000007F};
    base = writes.size();
    applyStimulus(3, 1);
    checkLoad("bad", base);
    checkOutput("bad_err_addr_first", {28'd0, err_addr}, 32'd1);

    // Zero length from IDLE: done next cycle, no bytes, no writes
    doReset();
    base = writes.size();
    rc = ready_cnt;
    startLoad(0);
    checkOutput("zero_done", {31'd0, done}, 32'd1);
    checkOutput("zero_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    repeat (4) tick();
    checkOutput("zero_no_write", writes.size() - base, 32'd0);
    checkOutput("zero_no_ready", ready_cnt - rc, 32'd0);

    // Reset in the middle of a load
    doReset();
    startLoad(2);
    for (int i = 0; i < 6; i++) sendByte(8'(i + 8'h40));
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("mid_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("mid_byte_ready", {31'd0, byte_ready}, 32'd0);
    #3 rst = 1'b0;
    tick();
    stim_words = '{32'h00A00093};
    base = writes.size();
    applyStimulus(1, 0);
    checkLoad("mid_reload", base);

    // start pulse during RECV is ignored
    stim_words = '{32'h00000013, 32'hFFFFFFFF};
    base = writes.size();
    startLoad(2);
    sendByte(8'h13);
    sendByte(8'h00);
    start = 1'b1;
    num_words = (AW + 1)'(5);
    tick();
    start = 1'b0;
    sendByte(8'h00); sendByte(8'h00);
    sendWord(32'hFFFFFFFF, 0);
    waitDone();
    checkLoad("recv_start", base);

    // Restart from DONE clears err
    stim_words = '{32'h00100013};
    base = writes.size();
    applyStimulus(1, 0);
    checkLoad("restart", base);

    // Opcode table, one single-word load per entry
    for (int i = 0; i < 12; i++) begin
      stim_words = '{vecs[i].word};
      base = writes.size();
      applyStimulus(1, 0);
      checkLoad("vec", base);
      checkOutput("vec_err_table", {31'd0, err}, {31'd0, vecs[i].exp_err});
    end

    // Oversized length clamps to memory capacity
    stim_words.delete();
    for (int i = 0; i < CAP; i++) stim_words.push_back({$urandom_range(0, 32'h1FFFFFF), 7'b0110011});
    base = writes.size();
    applyStimulus(31, 0);
    checkLoad("clamp", base);

    // Randomized loads with random gaps
    for (int it = 0; it < 20; it++) begin
      len = $urandom_range(1, 6);
      stim_words.delete();
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        if ($urandom_range(0, 2) != 0) w[6:0] = supported[$urandom_range(0, 6)];
        stim_words.push_back(w);
      end
      base = writes.size();
      applyStimulus(len, 2);
      checkLoad("rand", base);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
